calc_controller: RTL



---
 rtl/nn_pkg.sv | 18 +
 rtl/calc_watchdog.sv | 33 +++
 rtl/calc_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-net accelerator slice: row geometry,
// result width and the calculation sequencer state encoding.
package nn_pkg;

    localparam int NUM_ROWS = 10;
    localparam int ROW_W    = 4;
    localparam int RESULT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ROW,
        STORE,
        DONE,
        FAULT
    } calc_state_t;

endpackage

// File: rtl/calc_watchdog.sv
// Loadable up-counter used to bound how long the sequencer waits for the
// multiplier. It saturates at the expiry value so it can never wrap.
module calc_watchdog #(
    parameter int LIMIT = 2048,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    import nn_pkg::*;

    // Expiry is flagged on the last allowed cycle, LIMIT-1 counts after a load of zero
    assign expired = (count == CNT_W'(LIMIT - 1));

    // Count up while enabled, holding once the expiry value is reached
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Sequencer between the Avalon control interface and the row multiplier.
// One start_calc pulse walks every output row: issue, wait for the row,
// store the result, and finally report done_calc with sticky status flags.
module calc_controller #(
    parameter int NUM_ROWS       = nn_pkg::NUM_ROWS,
    parameter int ROW_W          = nn_pkg::ROW_W,
    parameter int RESULT_W       = nn_pkg::RESULT_W,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_calc,
    input  logic                clear_data,
    input  logic                done_row,
    input  logic [RESULT_W-1:0] row_result,
    input  logic                row_overflow,
    output logic                begin_mult,
    output logic [ROW_W-1:0]    row_select,
    output logic                w_result_ena,
    output logic [ROW_W-1:0]    output_address,
    output logic [RESULT_W:0]   result_output,
    output logic                busy,
    output logic                done_calc,
    output logic                overflow,
    output logic                timeout
);

    import nn_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    calc_state_t      state;
    logic [ROW_W-1:0] row;
    logic [WD_W-1:0]  wd_count;
    logic             wd_expired;

    // Watchdog is zeroed while a row is issued and runs only while waiting for it
    calc_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_data),
        .load       (state == ISSUE),
        .load_value ('0),
        .enable     (state == WAIT_ROW),
        .count      (wd_count),
        .expired    (wd_expired)
    );

    // Strobes and status levels decode straight from the state register so
    // they are glitch-free and each pulse lasts exactly one state cycle
    assign begin_mult     = (state == ISSUE);
    assign w_result_ena   = (state == STORE);
    assign busy           = (state == ISSUE) || (state == WAIT_ROW) || (state == STORE);
    assign done_calc      = (state == DONE);
    assign row_select     = row;
    assign output_address = row;

    // Main sequencer: reset and abort share one path, then per-state transitions
    always_ff @(posedge clk) begin
        if (rst || clear_data) begin
            state         <= IDLE;
            row           <= '0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
            result_output <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_calc) begin
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                        row      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ROW;
                end
                WAIT_ROW: begin
                    if (done_row) begin
                        result_output <= {row_overflow, row_result};
                        overflow      <= overflow | row_overflow;
                        state         <= STORE;
                    end else if (wd_expired) begin
                        timeout <= 1'b1;
                        state   <= FAULT;
                    end
                end
                STORE: begin
                    if (row == LAST_ROW) begin
                        state <= DONE;
                    end else begin
                        row   <= row + ROW_W'(1);
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    if (start_calc) begin
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                        row      <= '0;
                        state    <= ISSUE;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
